// File: rtl/mips_bist_ctrl.sv
// mips_bist_ctrl
//   BIST session controller sitting between the CPU data-memory write port
//   and the MIPS-16 output response analyzer (ORA). In IDLE the CPU write
//   traffic is passed through to the ORA. A session clears the ORA, drives
//   N deterministic address/data vectors into it, captures the 32-bit
//   signature and compares it with a programmed golden value.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        session request / session termination
//   cfg_len             number of vectors N (0..65535)
//   cfg_seed            data LFSR seed (0 is replaced by 16'hACE1)
//   cfg_golden          expected signature
//   func_addr/wdata/we  functional write traffic from the CPU
//   func_stall          CPU must hold its request while high
//   ora_addr/wdata/we   ORA access_addr / write_data / write_en
//   ora_clr             registered clear pulse for the ORA
//   ora_sig             ORA signature (read_data)
//   busy, done          session in progress / normal completion pulse
//   pass, fail          sticky result of the last completed session
//   sig_out             signature captured at the end of the last session
module mips_bist_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SIG_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       cfg_len,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [SIG_W-1:0]  cfg_golden,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_wdata,
    input  logic              func_we,
    output logic              func_stall,
    output logic [ADDR_W-1:0] ora_addr,
    output logic [DATA_W-1:0] ora_wdata,
    output logic              ora_we,
    output logic              ora_clr,
    input  logic [SIG_W-1:0]  ora_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [SIG_W-1:0]  sig_out
);

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [15:0]        len_q,    len_d;
    logic [15:0]        cnt_q,    cnt_d;
    logic [15:0]        lfsr_q,   lfsr_d;
    logic [SIG_W-1:0]   golden_q, golden_d;
    logic [SIG_W-1:0]   sig_q,    sig_d;
    logic               pass_q,   pass_d;
    logic               fail_q,   fail_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;
    logic               clr_q,    clr_d;

    logic [15:0]        seed_in;
    logic [15:0]        lfsr_step;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign seed_in   = (16'(cfg_seed) == 16'h0000) ? SEED_DEFAULT : 16'(cfg_seed);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        golden_d = golden_q;
        sig_d    = sig_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        done_d   = 1'b0;
        clr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // abort wins over a simultaneous start
                if (abort) begin
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                end else if (start) begin
                    state_d  = CLEAR;
                    len_d    = cfg_len;
                    lfsr_d   = seed_in;
                    golden_d = cfg_golden;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    clr_d    = 1'b1;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end else begin
                    state_d = (len_q != 16'd0) ? RUN : CHECK;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                    lfsr_d = lfsr_step;
                    // len_q >= 1 here, so the subtraction cannot underflow
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                sig_d   = ora_sig;
                pass_d  = (ora_sig == golden_q);
                fail_d  = (ora_sig != golden_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            lfsr_q   <= SEED_DEFAULT;
            golden_q <= '0;
            sig_q    <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            golden_q <= golden_d;
            sig_q    <= sig_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            clr_q    <= clr_d;
        end
    end

    // ORA port mux: CPU passthrough in IDLE, generated vectors in RUN,
    // quiet in CLEAR and CHECK
    always_comb begin
        ora_addr  = '0;
        ora_wdata = '0;
        ora_we    = 1'b0;
        case (state_q)
            IDLE: begin
                ora_addr  = func_addr;
                ora_wdata = func_wdata;
                ora_we    = func_we;
            end
            RUN: begin
                ora_addr  = ADDR_W'(cnt_q);
                ora_wdata = DATA_W'(lfsr_q);
                ora_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ora_clr    = clr_q;
    assign busy       = busy_q;
    assign func_stall = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign sig_out    = sig_q;

endmodule

// File: tb/tb_mips_bist_ctrl.sv
// tb_mips_bist_ctrl
//   Scoreboard bench for mips_bist_ctrl. Each session pushes its expected
//   ORA vectors and expected result into queues; a negedge monitor pops and
//   compares whenever the DUT writes the ORA during a session or pulses done.
module tb_mips_bist_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int SIG_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [15:0]       cfg_len;
    logic [DATA_W-1:0] cfg_seed;
    logic [SIG_W-1:0]  cfg_golden;
    logic [ADDR_W-1:0] func_addr;
    logic [DATA_W-1:0] func_wdata;
    logic              func_we;
    logic              func_stall;
    logic [ADDR_W-1:0] ora_addr;
    logic [DATA_W-1:0] ora_wdata;
    logic              ora_we;
    logic              ora_clr;
    logic [SIG_W-1:0]  ora_sig;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic [SIG_W-1:0]  sig_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] vec_q[$];   // {addr, wdata}
    logic [33:0] res_q[$];   // {pass, fail, sig}

    mips_bist_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SIG_W (SIG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .cfg_seed  (cfg_seed),
        .cfg_golden(cfg_golden),
        .func_addr (func_addr),
        .func_wdata(func_wdata),
        .func_we   (func_we),
        .func_stall(func_stall),
        .ora_addr  (ora_addr),
        .ora_wdata (ora_wdata),
        .ora_we    (ora_we),
        .ora_clr   (ora_clr),
        .ora_sig   (ora_sig),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .sig_out   (sig_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference data generator: taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                chk("stall_busy", {31'b0, func_stall}, 32'd1);
                if (ora_we) begin
                    if (vec_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL vec_unexpected: got addr %h data %h expected no write", ora_addr, ora_wdata);
                    end else begin
                        chk("vector", {ora_addr, ora_wdata}, vec_q.pop_front());
                    end
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1 expected no done");
                end else begin
                    logic [33:0] e;
                    e = res_q.pop_front();
                    chk("pass",    {31'b0, pass}, {31'b0, e[33]});
                    chk("fail",    {31'b0, fail}, {31'b0, e[32]});
                    chk("sig_out", sig_out, e[31:0]);
                    chk("busy_at_done", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    // One session. abort_k / repulse_k / rst_k < 0 disable those events;
    // with push_model = 0 the caller has already queued the vectors.
    task automatic run_session(input int n, input logic [15:0] seed,
                               input logic [31:0] golden, input logic [31:0] sig,
                               input bit push_model, input int abort_k,
                               input int repulse_k, input int rst_k);
        logic [15:0] s;
        logic [31:0] prev_sig;
        int nvec;
        bit seen;
        s = (seed == 16'h0000) ? 16'hACE1 : seed;
        nvec = n;
        if (abort_k >= 0) nvec = abort_k + 1;
        if (rst_k >= 0)   nvec = rst_k + 1;
        if (push_model) begin
            for (int k = 0; k < nvec; k++) begin
                vec_q.push_back({k[15:0], s});
                s = lfsr_next(s);
            end
        end
        if (abort_k < 0 && rst_k < 0)
            res_q.push_back({sig == golden, sig != golden, sig});
        prev_sig   = sig_out;
        cfg_len    = n[15:0];
        cfg_seed   = seed;
        cfg_golden = golden;
        ora_sig    = sig;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // config must be latched: scramble it once accepted
        cfg_len    = 16'hFFFF;
        cfg_seed   = ~seed;
        cfg_golden = ~golden;
        chk("clr_pulse", {31'b0, ora_clr}, 32'd1);
        chk("busy_start", {31'b0, busy}, 32'd1);
        chk("clr_we", {31'b0, ora_we}, 32'd0);
        seen = 1'b0;
        for (int idx = 1; idx <= n + 8; idx++) begin
            @(negedge clk);
            start = (repulse_k >= 0 && idx == repulse_k + 1);
            if (idx == 1) chk("clr_end", {31'b0, ora_clr}, 32'd0);
            if (abort_k >= 0 && idx == abort_k + 1) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", {31'b0, busy}, 32'd0);
                chk("abort_done", {31'b0, done}, 32'd0);
                chk("abort_pf", {30'b0, pass, fail}, 32'd0);
                chk("abort_sig", sig_out, prev_sig);
                return;
            end
            if (rst_k >= 0 && idx == rst_k + 1) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_outs", {27'b0, busy, done, pass, fail, ora_clr}, 32'd0);
                chk("rst_stall", {31'b0, func_stall}, 32'd0);
                chk("rst_sig", sig_out, 32'd0);
                chk("rst_pass", {ora_addr, ora_wdata}, {func_addr, func_wdata});
                chk("rst_pass_we", {31'b0, ora_we}, {31'b0, func_we});
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) begin
                chk("done_latency", idx, n + 2);
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done at %0d", n + 2);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_len    = '0;
        cfg_seed   = '0;
        cfg_golden = '0;
        func_addr  = '0;
        func_wdata = '0;
        func_we    = 1'b0;
        ora_sig    = '0;

        repeat (2) @(negedge clk);
        chk("reset_outs", {27'b0, busy, done, pass, fail, ora_clr}, 32'd0);
        chk("reset_stall", {31'b0, func_stall}, 32'd0);
        chk("reset_sig", sig_out, 32'd0);
        rst = 1'b0;

        // passthrough in IDLE; traffic stays asserted through all sessions
        @(negedge clk);
        func_we    = 1'b1;
        func_addr  = 16'h1234;
        func_wdata = 16'hBEEF;
        #1;
        chk("pt_addr",  {16'b0, ora_addr},  32'h1234);
        chk("pt_wdata", {16'b0, ora_wdata}, 32'hBEEF);
        chk("pt_we",    {31'b0, ora_we},    32'd1);
        chk("pt_stall", {31'b0, func_stall}, 32'd0);
        @(negedge clk);

        // empty session: no ORA writes, done two cycles after start
        run_session(0, 16'h0001, 32'h00000001, 32'h00000001, 1'b0, -1, -1, -1);

        // single vector, pass then fail (back-to-back starts)
        vec_q.push_back({16'h0000, 16'h0001});
        run_session(1, 16'h0001, 32'h00400005, 32'h00400005, 1'b0, -1, -1, -1);
        vec_q.push_back({16'h0000, 16'h0001});
        run_session(1, 16'h0001, 32'h00400004, 32'h00400005, 1'b0, -1, -1, -1);

        // seed 0 is replaced by ACE1
        vec_q.push_back({16'h0000, 16'hACE1});
        vec_q.push_back({16'h0001, 16'h59C3});
        run_session(2, 16'h0000, 32'h12345678, 32'h12345678, 1'b0, -1, -1, -1);

        // start re-pulsed mid-RUN is ignored
        run_session(8, 16'h1234, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, -1, 3, -1);

        // abort at k=500, then a full 1000-vector session ending in fail
        run_session(1000, 16'h5A5A, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 500, -1, -1);
        run_session(1000, 16'h5A5A, 32'hDEADBEEF, 32'hDEADBEEE, 1'b1, -1, -1, -1);

        // start and abort together in IDLE: no session
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", {31'b0, busy}, 32'd0);
        chk("sa_clr",  {31'b0, ora_clr}, 32'd0);
        @(negedge clk);
        chk("sa_busy2", {31'b0, busy}, 32'd0);

        // reset mid-RUN at k=50 of 100
        run_session(100, 16'hBEEF, 32'h0, 32'h0, 1'b1, -1, -1, 50);
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);

        chk("vec_q_drained", vec_q.size(), 32'd0);
        chk("res_q_drained", res_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
